mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 33 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the memory arbiter
// Holds the d_type codes, the FSM state codes, the wait-state default and the alignment helper.
package mem_arbiter_pkg;
    localparam int WAIT_STATES_DEFAULT = 2;
    localparam logic [1:0] T_BYTE  = 2'b00;
    localparam logic [1:0] T_HALF  = 2'b01;
    localparam logic [1:0] T_WORD  = 2'b10;
    localparam logic [1:0] T_DWORD = 2'b11;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCESS = 3'd1;
    localparam logic [2:0] S_BEAT2  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    function automatic logic misaligned(input logic [1:0] t, input logic [2:0] a);
        return (t == T_HALF && a[0]) || (t == T_WORD && a[1:0] != 2'b00) || (t == T_DWORD && a != 3'b000);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane steering for the memory arbiter
// Ports: dtype/sgn/off describe the access, beat2 selects the doubleword low half,
// wdata is the right-justified write data, rdata the RAM word, hi the captured first beat;
// be/lane_wdata drive the RAM, lane_rdata is the right-justified, extended read result.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  dtype,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic        beat2,
    input  logic [63:0] wdata,
    input  logic [31:0] rdata,
    input  logic [31:0] hi,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [63:0] lane_rdata
);
    logic [7:0]  byt;
    logic [15:0] half;
    // offset 0 lives in bits 31:24, so the addressed byte sits 8*(3-off) bits up
    assign byt  = 8'(rdata >> {~off, 3'b000});
    assign half = off[1] ? rdata[15:0] : rdata[31:16];
    always_comb begin
        be = dtype == T_BYTE ? 4'b1000 >> off : dtype == T_HALF ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        lane_wdata = dtype == T_BYTE ? {4{wdata[7:0]}} :
                     dtype == T_HALF ? {2{wdata[15:0]}} :
                     dtype == T_DWORD && !beat2 ? wdata[63:32] : wdata[31:0];
        lane_rdata = dtype == T_BYTE ? {{56{sgn & byt[7]}}, byt} :
                     dtype == T_HALF ? {{48{sgn & half[15]}}, half} :
                     dtype == T_WORD ? {32'd0, rdata} : {hi, rdata};
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one 32-bit RAM between instruction fetch and data ports
// Ports: clk/clr (async active-low reset); if_req/if_addr -> if_moc/if_data fetch port;
// d_req/d_rw/d_type/d_signed/d_addr/d_wdata -> d_moc/d_rdata/d_misalign data port;
// mem_en/mem_we/mem_addr/mem_be/mem_wdata/mem_rdata RAM port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_moc,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_type,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_moc,
    output logic [63:0] d_rdata,
    output logic        d_misalign,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    logic [2:0]  state;
    logic [3:0]  cnt;
    logic        last_d, g_d, rw, sgn;
    logic [1:0]  dtype;
    logic [31:0] addr, hi, if_q;
    logic [63:0] wdata, d_q;
    logic        grant_d, active, beat2, last;
    logic [3:0]  be;
    logic [31:0] lane_wdata;
    logic [63:0] lane_rdata;
    // data wins when it is the only requester or fetch was granted last
    assign grant_d = d_req & (~if_req | ~last_d);
    assign active  = state == S_ACCESS || state == S_BEAT2;
    assign beat2   = state == S_BEAT2;
    assign last    = cnt == WS;
    mem_lane_align u_lane (
        .dtype      (dtype),
        .sgn        (sgn),
        .off        (addr[1:0]),
        .beat2      (beat2),
        .wdata      (wdata),
        .rdata      (mem_rdata),
        .hi         (hi),
        .be         (be),
        .lane_wdata (lane_wdata),
        .lane_rdata (lane_rdata)
    );
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            last_d <= 1'b1;
            g_d    <= 1'b0;
            rw     <= 1'b0;
            sgn    <= 1'b0;
            dtype  <= T_BYTE;
            addr   <= 32'd0;
            wdata  <= 64'd0;
            hi     <= 32'd0;
            if_q   <= 32'd0;
            d_q    <= 64'd0;
        end else if (state == S_IDLE && (if_req || d_req)) begin
            g_d    <= grant_d;
            last_d <= grant_d;
            cnt    <= 4'd0;
            addr   <= grant_d ? d_addr : if_addr;
            dtype  <= grant_d ? d_type : T_WORD;
            rw     <= grant_d ? d_rw : 1'b1;
            sgn    <= grant_d & d_signed;
            wdata  <= d_wdata;
            state  <= grant_d && misaligned(d_type, d_addr[2:0]) ? S_ERR : S_ACCESS;
        end else if (active) begin
            cnt <= last ? 4'd0 : cnt + 4'd1;
            if (last && !beat2 && g_d && dtype == T_DWORD) begin
                hi    <= mem_rdata;
                state <= S_BEAT2;
            end else if (last) begin
                state <= S_DONE;
                if (g_d)
                    d_q <= lane_rdata;
                else
                    if_q <= mem_rdata;
            end
        end else if (state == S_DONE || state == S_ERR) begin
            state <= S_IDLE;
        end
    end
    assign mem_en     = active;
    assign mem_we     = active & ~rw;
    assign mem_be     = active ? be : 4'd0;
    // doubleword addresses are 8-aligned, so bit 2 alone selects the second beat
    assign mem_addr   = active ? {addr[31:3], addr[2] | beat2, 2'b00} : 32'd0;
    assign mem_wdata  = active ? lane_wdata : 32'd0;
    assign if_moc     = state == S_DONE && !g_d;
    assign d_moc      = state == S_DONE && g_d;
    assign d_misalign = state == S_ERR;
    assign if_data    = if_q;
    assign d_rdata    = d_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int W = 2;
    logic        clk = 1'b0, clr = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_rw = 1'b0, d_signed = 1'b0;
    logic [31:0] if_addr = 32'd0, d_addr = 32'd0;
    logic [1:0]  d_type = 2'b00;
    logic [63:0] d_wdata = 64'd0;
    logic        if_moc, d_moc, d_misalign, mem_en, mem_we;
    logic [31:0] if_data, mem_addr, mem_wdata, mem_rdata;
    logic [63:0] d_rdata;
    logic [3:0]  mem_be;
    logic [31:0] ram_fixed = 32'd0;
    bit          use_fixed = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_STATES(W)) dut (
        .clk(clk), .clr(clr),
        .if_req(if_req), .if_addr(if_addr), .if_moc(if_moc), .if_data(if_data),
        .d_req(d_req), .d_rw(d_rw), .d_type(d_type), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_moc(d_moc), .d_rdata(d_rdata),
        .d_misalign(d_misalign), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] hash(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h7F4A7C15;
    endfunction

    always_comb mem_rdata = use_fixed ? ram_fixed : hash(mem_addr);

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return use_fixed ? ram_fixed : hash(a);
    endfunction

    function automatic logic [63:0] exp_read(input logic [1:0] t, input bit sg, input logic [31:0] a);
        logic [31:0] wd;
        logic [63:0] v;
        int sz;
        wd = ram_word({a[31:2], 2'b00});
        if (t == 2'b11) return {wd, ram_word({a[31:2], 2'b00} + 32'd4)};
        sz = 1 << t;
        v = 64'd0;
        for (int j = int'(a[1:0]); j < int'(a[1:0]) + sz; j++) v = (v << 8) | 64'(wd[31 - 8 * j -: 8]);
        if (sg && sz < 4 && v[8 * sz - 1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] t, input logic [31:0] a);
        logic [3:0] b;
        int sz;
        sz = 1 << t;
        if (sz >= 4) return 4'b1111;
        b = 4'b0000;
        for (int j = int'(a[1:0]); j < int'(a[1:0]) + sz; j++) b[3 - j] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] t, input logic [63:0] w, input int beat);
        if (t == 2'b00) return {4{w[7:0]}};
        if (t == 2'b01) return {2{w[15:0]}};
        if (t == 2'b11 && beat == 0) return w[63:32];
        return w[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_be"}, 64'(mem_be), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_moc"}, 64'({if_moc, d_moc, d_misalign}), 64'd0);
    endtask

    // Call at a negedge of an idle cycle; returns at a negedge of an idle cycle.
    task automatic txn(input bit isd, input bit rw, input logic [1:0] t, input bit sg,
                       input logic [31:0] a, input logic [63:0] w, input bit drop);
        int sz, beats, lat, beat;
        bit mis, en_exp;
        logic [1:0] tt;
        tt = isd ? t : 2'b10;
        sz = 1 << tt;
        mis = isd && ((a & 32'(sz - 1)) != 32'd0);
        beats = (tt == 2'b11) ? 2 : 1;
        lat = mis ? 1 : beats * (W + 1) + 1;
        if (isd) begin
            d_req = 1'b1; d_rw = rw; d_type = t; d_signed = sg; d_addr = a; d_wdata = w;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int i = 1; i <= lat + 1; i++) begin
            @(negedge clk);
            if (drop && i == 1) begin
                if_req = 1'b0; d_req = 1'b0;
                d_addr = ~a; d_wdata = ~w; if_addr = ~a;
            end
            en_exp = !mis && i <= beats * (W + 1);
            chk("mem_en", 64'(mem_en), 64'(en_exp));
            if (en_exp) begin
                beat = (i - 1) / (W + 1);
                chk("mem_addr", 64'(mem_addr), 64'({a[31:2], 2'b00} + 32'(4 * beat)));
                chk("mem_be", 64'(mem_be), 64'(exp_be(tt, a)));
                chk("mem_we", 64'(mem_we), 64'(isd && !rw));
                if (isd && !rw) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wd(t, w, beat)));
            end
            chk("if_moc", 64'(if_moc), 64'(!isd && i == lat));
            chk("d_moc", 64'(d_moc), 64'(isd && !mis && i == lat));
            chk("d_misalign", 64'(d_misalign), 64'(mis && i == lat));
            if (i == lat) begin
                if (!isd) chk("if_data", 64'(if_data), 64'(ram_word({a[31:2], 2'b00})));
                else if (!mis && rw) chk("d_rdata", d_rdata, exp_read(t, sg, a));
                if_req = 1'b0; d_req = 1'b0;
            end
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset_if_data", 64'(if_data), 64'd0);
        chk("reset_d_rdata", d_rdata, 64'd0);
        clr = 1'b1;
        // both requesters from the first cycle: fetch, data, fetch
        if_addr = 32'h400; d_rw = 1'b1; d_type = 2'b10; d_signed = 1'b0; d_addr = 32'h500;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 1; i <= 3 * W + 8; i++) begin
            @(negedge clk);
            chk("rr_if_moc", 64'(if_moc), 64'(i == W + 2 || i == 3 * W + 8));
            chk("rr_d_moc", 64'(d_moc), 64'(i == 2 * W + 5));
            if (i == W + 2) chk("rr_if_data", 64'(if_data), 64'(hash(32'h400)));
            if (i == 2 * W + 5) chk("rr_d_rdata", d_rdata, 64'(hash(32'h500)));
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        use_fixed = 1'b1;
        ram_fixed = 32'h81C3E008;
        txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 64'd0, 1'b0);
        chk("fetch_0x100", 64'(if_data), 64'h81C3E008);
        ram_fixed = 32'h112233F0;
        txn(1'b1, 1'b1, 2'b00, 1'b1, 32'h203, 64'd0, 1'b0);
        chk("sbyte_0x203", d_rdata, 64'hFFFFFFFFFFFFFFF0);
        use_fixed = 1'b0;
        txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h208, 64'hAABBCCDD11223344, 1'b0);
        txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h302, 64'd0, 1'b0);
        // reset in the middle of an access
        d_req = 1'b1; d_rw = 1'b1; d_type = 2'b10; d_addr = 32'h700;
        repeat (2) @(negedge clk);
        chk("pre_reset_en", 64'(mem_en), 64'd1);
        #1 clr = 1'b0;
        #1 chk_quiet("async_reset");
        chk("async_reset_d_rdata", d_rdata, 64'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk_quiet("held_reset");
        clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("post_reset");
        end
        txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h600, 64'd0, 1'b0);
        for (int k = 0; k < 80; k++) begin
            logic [1:0] ty;
            logic [31:0] a;
            t = $urandom % 3;
            ty = 2'($urandom);
            a = 32'h1000 + ($urandom % 256);
            if ($urandom % 2 == 1) a = a & ~32'((1 << ty) - 1);
            txn(t != 0, 1'($urandom), ty, 1'($urandom), a, {$urandom, $urandom}, ($urandom % 4) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
